// File: rtl/cordic_angle_prep_if.sv
// Request/response bundle between the angle source and the CORDIC front-end.
// The master drives the angle request and the seed acknowledge.
// The slave (the front-end) returns status and the seed vector.
interface cordic_angle_prep_if #(
  parameter int DATA_WIDTH = 20,
  parameter int PHI_WIDTH  = 22
);
  logic                  start_in;
  logic [PHI_WIDTH-2:0]  angle_in;
  logic                  out_ack;
  logic                  busy;
  logic                  rst_step;
  logic                  enable;
  logic                  data_out;
  logic [DATA_WIDTH-1:0] X_out;
  logic [DATA_WIDTH-1:0] Y_out;
  logic [PHI_WIDTH-1:0]  phi_veer_out;
  logic [1:0]            quarter_out;

  modport master (
    output start_in, angle_in, out_ack,
    input  busy, rst_step, enable, data_out, X_out, Y_out, phi_veer_out, quarter_out
  );

  modport slave (
    input  start_in, angle_in, out_ack,
    output busy, rst_step, enable, data_out, X_out, Y_out, phi_veer_out, quarter_out
  );
endinterface

// File: rtl/cordic_angle_prep.sv
// CORDIC front-end: reduces an angle in degrees to a first-quadrant residual
// plus a quarter code. It then presents the X=K, Y=0 seed vector to the
// first iteration stage.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start_in; outputs hold the last result
// WRAP  | one conditional subtraction of 360 deg (input < 512 deg)
// QUAD  | strip 90 deg per cycle, counting quarters, until acc < 90
// OUT   | seed vector valid, waiting for out_ack
module cordic_angle_prep #(
  parameter int DATA_WIDTH = 20,
  parameter int DATA_FRAC  = 18,
  parameter int PHI_WIDTH  = 22,
  parameter int PHI_FRAC   = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  cordic_angle_prep_if.slave   bus
);

  localparam int MAG_W = PHI_WIDTH - 1;

  localparam logic [MAG_W-1:0] FULL_TURN    = MAG_W'(360 << PHI_FRAC);
  localparam logic [MAG_W-1:0] QUARTER_TURN = MAG_W'(90 << PHI_FRAC);

  // CORDIC gain compensation, rounded to nearest in the X/Y fixed-point format.
  localparam real              K_REAL = 0.6072529350 * (2.0 ** DATA_FRAC);
  localparam logic [DATA_WIDTH-1:0] K_SEED = DATA_WIDTH'($rtoi(K_REAL + 0.5));

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WRAP = 2'd1,
    QUAD = 2'd2,
    OUT  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [MAG_W-1:0]      acc_q, acc_d;
  logic [1:0]            q_q, q_d;
  logic                  busy_q, busy_d;
  logic                  rst_step_q, rst_step_d;
  logic                  data_q, data_d;
  logic [DATA_WIDTH-1:0] x_q, x_d;
  logic [DATA_WIDTH-1:0] y_q, y_d;
  logic [PHI_WIDTH-1:0]  phi_q, phi_d;
  logic [1:0]            quarter_q, quarter_d;

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    q_d        = q_q;
    rst_step_d = 1'b0;
    data_d     = data_q;
    x_d        = x_q;
    y_d        = y_q;
    phi_d      = phi_q;
    quarter_d  = quarter_q;

    case (state_q)
      IDLE: begin
        if (bus.start_in) begin
          acc_d      = bus.angle_in;
          q_d        = 2'd0;
          rst_step_d = 1'b1;
          state_d    = WRAP;
        end
      end
      WRAP: begin
        if (acc_q >= FULL_TURN) begin
          acc_d = acc_q - FULL_TURN;
        end
        state_d = QUAD;
      end
      QUAD: begin
        if (acc_q >= QUARTER_TURN) begin
          acc_d = acc_q - QUARTER_TURN;
          q_d   = q_q + 2'd1;
        end else begin
          phi_d     = {1'b0, acc_q};
          quarter_d = q_q;
          x_d       = K_SEED;
          y_d       = '0;
          data_d    = 1'b1;
          state_d   = OUT;
        end
      end
      OUT: begin
        // A simultaneous start is dropped: only IDLE looks at start_in.
        if (bus.out_ack) begin
          data_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      q_q        <= 2'd0;
      busy_q     <= 1'b0;
      rst_step_q <= 1'b0;
      data_q     <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      phi_q      <= '0;
      quarter_q  <= 2'd0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      q_q        <= q_d;
      busy_q     <= busy_d;
      rst_step_q <= rst_step_d;
      data_q     <= data_d;
      x_q        <= x_d;
      y_q        <= y_d;
      phi_q      <= phi_d;
      quarter_q  <= quarter_d;
    end
  end

  assign bus.busy         = busy_q;
  assign bus.rst_step     = rst_step_q;
  assign bus.data_out     = data_q;
  assign bus.enable       = data_q;
  assign bus.X_out        = x_q;
  assign bus.Y_out        = y_q;
  assign bus.phi_veer_out = phi_q;
  assign bus.quarter_out  = quarter_q;

endmodule

// File: tb/tb_cordic_angle_prep.sv
// Scoreboard bench for cordic_angle_prep: an expected result is queued at
// each accepted request and compared when the seed vector appears.
module tb_cordic_angle_prep;

  localparam int ONE_DEG = 4096;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  cordic_angle_prep_if bus ();

  cordic_angle_prep dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [21:0] phi;
    logic [1:0]  quarter;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [20:0] a);
    int unsigned v;
    exp_t e;
    v = a;
    if (v >= 360 * ONE_DEG) v = v - 360 * ONE_DEG;
    e.quarter = 2'(v / (90 * ONE_DEG));
    e.phi     = 22'(v % (90 * ONE_DEG));
    e.lat     = int'(v / (90 * ONE_DEG)) + 3;
    return e;
  endfunction

  task automatic check_reset(input string pfx);
    check({pfx, "_busy"},     32'(bus.busy), 0);
    check({pfx, "_rst_step"}, 32'(bus.rst_step), 0);
    check({pfx, "_enable"},   32'(bus.enable), 0);
    check({pfx, "_data_out"}, 32'(bus.data_out), 0);
    check({pfx, "_x"},        32'(bus.X_out), 0);
    check({pfx, "_y"},        32'(bus.Y_out), 0);
    check({pfx, "_phi"},      32'(bus.phi_veer_out), 0);
    check({pfx, "_quarter"},  32'(bus.quarter_out), 0);
  endtask

  // Called at a negedge in IDLE; returns at the negedge after the accept edge.
  task automatic accept(input logic [20:0] a);
    sb.push_back(model(a));
    bus.start_in = 1'b1;
    bus.angle_in = a;
    @(negedge clk);
    bus.start_in = 1'b0;
    check("accept_busy",     32'(bus.busy), 1);
    check("accept_rst_step", 32'(bus.rst_step), 1);
  endtask

  // Waits for the seed vector, checks it, holds, then acknowledges.
  task automatic collect(input int hold, input bit glitch);
    int   edges;
    exp_t e;
    edges = 1;
    @(negedge clk);
    edges = 2;
    check("rst_step_pulse_end", 32'(bus.rst_step), 0);
    if (glitch) begin
      bus.start_in = 1'b1;
      bus.angle_in = 21'(10 * ONE_DEG);
    end
    while (!bus.data_out && edges < 20) begin
      @(negedge clk);
      bus.start_in = 1'b0;
      edges++;
    end
    check("data_out_seen", 32'(bus.data_out), 1);
    if (sb.size() == 0) begin
      check("scoreboard_nonempty", 0, 1);
      return;
    end
    e = sb.pop_front();
    check("latency", 32'(edges),           32'(e.lat));
    check("quarter", 32'(bus.quarter_out), 32'(e.quarter));
    check("phi",     32'(bus.phi_veer_out),32'(e.phi));
    check("x_seed",  32'(bus.X_out),       32'h26DD4);
    check("y_seed",  32'(bus.Y_out),       0);
    check("enable",  32'(bus.enable),      1);
    check("busy_out",32'(bus.busy),        1);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_data_out", 32'(bus.data_out),     1);
      check("hold_phi",      32'(bus.phi_veer_out), 32'(e.phi));
      check("hold_quarter",  32'(bus.quarter_out),  32'(e.quarter));
    end
    bus.out_ack = 1'b1;
    if (glitch) begin
      bus.start_in = 1'b1;
      bus.angle_in = 21'(20 * ONE_DEG);
    end
    @(negedge clk);
    bus.out_ack  = 1'b0;
    bus.start_in = 1'b0;
    check("ack_data_out", 32'(bus.data_out),     0);
    check("ack_enable",   32'(bus.enable),       0);
    check("ack_busy",     32'(bus.busy),         0);
    check("ack_phi_kept", 32'(bus.phi_veer_out), 32'(e.phi));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start_in = 1'b0;
    bus.angle_in = '0;
    bus.out_ack  = 1'b0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst = 1'b1;
    @(negedge clk);

    accept(21'h1E000);            collect(0, 1'b0);
    accept(21'(200 * ONE_DEG));   collect(10, 1'b0);
    accept(21'(90 * ONE_DEG));    collect(0, 1'b0);
    accept(21'(360 * ONE_DEG));   collect(0, 1'b0);
    accept(21'(450 * ONE_DEG));   collect(0, 1'b0);
    accept(21'h167FFF);           collect(0, 1'b0);
    accept(21'(0));               collect(0, 1'b0);
    accept(21'(512 * ONE_DEG - 1)); collect(0, 1'b0);

    // Starts during QUAD and together with out_ack are ignored.
    accept(21'(100 * ONE_DEG));   collect(2, 1'b1);
    // A start on the first cycle back in IDLE is accepted.
    accept(21'(45 * ONE_DEG));    collect(0, 1'b0);

    for (int i = 0; i < 6; i++) begin
      accept(21'($urandom_range(512 * ONE_DEG - 1, 0)));
      collect(1, 1'b0);
    end

    // Reset during the second QUAD cycle of 300 degrees.
    accept(21'(300 * ONE_DEG));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset("midreset");
    rst = 1'b1;
    void'(sb.pop_back());
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("midreset_no_data", 32'(bus.data_out), 0);
    end
    accept(21'(45 * ONE_DEG));    collect(0, 1'b0);

    check("scoreboard_empty", 32'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cordic_angle_prep.md
# cordic_angle_prep

Front-end stage of the CORDIC sine/cosine pipeline, placed directly upstream of the first `cordic_alg_block` (ITER=0). It accepts an angle in degrees and reduces it modulo 360 into a first-quadrant residual plus a 2-bit quarter code. It then presents the pipeline seed vector X=K, Y=0 and phi=residual, with `data_out` and `enable` asserted. It also issues a one-cycle `rst_step` pulse so that the iteration stages clear their `done` flags before each new operation.

## Interface
- `DATA_WIDTH`, default 20: width of X/Y. Sign-magnitude: bit DATA_WIDTH-1 is the sign, the rest is magnitude.
- `DATA_FRAC`, default 18: fractional bits of X/Y.
- `PHI_WIDTH`, default 22: width of phi. Sign-magnitude, degrees.
- `PHI_FRAC`, default 12: fractional bits of phi. The default format is 1 sign bit, 9 integer bits and 12 fraction bits.
- `clk`, input, 1: single clock. All state changes on the rising edge.
- `rst`, input, 1: reset. Synchronous and active-low (0 = reset).
- `start_in`, input, 1: request. Sampled only in IDLE.
- `angle_in`, input, PHI_WIDTH-1: unsigned angle magnitude. Valid range [0, 512) degrees.
- `out_ack`, input, 1: consumer has taken the seed vector. Sampled only in OUT.
- `busy`, output, 1: high in every state except IDLE.
- `rst_step`, output, 1: one-cycle clear pulse to the downstream stages.
- `enable`, output, 1: pipeline enable. Equal to `data_out`.
- `data_out`, output, 1: seed vector valid.
- `X_out`, output, DATA_WIDTH: seed X.
- `Y_out`, output, DATA_WIDTH: seed Y.
- `phi_veer_out`, output, PHI_WIDTH: residual angle. Sign bit is always 0.
- `quarter_out`, output, 2: quarter code. 0 = [0,90), 1 = [90,180), 2 = [180,270), 3 = [270,360).

## Operation
- FSM states: IDLE, WRAP, QUAD, OUT. Internal registers: angle accumulator `acc` (PHI_WIDTH-1 bits) and quarter counter `q` (2 bits).
- IDLE: when `start_in`=1, capture `acc`←`angle_in`, set `q`←0, assert `rst_step` for the next cycle, and go to WRAP. When `start_in`=0, stay in IDLE.
- WRAP: if `acc` ≥ 360·2^PHI_FRAC, subtract 360·2^PHI_FRAC (at most one subtraction over the legal input range). Go to QUAD.
- QUAD, evaluated once per cycle:
  - If `acc` ≥ 90·2^PHI_FRAC: subtract 90·2^PHI_FRAC, increment `q`, and stay in QUAD.
  - Otherwise: load the outputs and go to OUT.
  - `q` never exceeds 3 after WRAP; no wrap-around of `q` is possible.
- OUT load values:
  - `phi_veer_out` = {1'b0, acc}
  - `quarter_out` = q
  - `X_out` = K = round(0.6072529350·2^DATA_FRAC), which is 0x26DD4 for the defaults
  - `Y_out` = 0
  - `data_out` = `enable` = 1
- OUT: all outputs hold while `out_ack`=0. When `out_ack`=1, deassert `data_out`/`enable` and go to IDLE on that edge. The X/Y/phi/quarter outputs keep their last values.
- Arithmetic is unsigned on the magnitude bits only. Residual range is [0, 90)·2^PHI_FRAC. Comparisons are exact: an input of exactly 90.0 yields quarter 1 with residual 0.
- Boundary and precedence rules:
  - `start_in` outside IDLE is ignored; no queueing.
  - `start_in` and `out_ack` both high in OUT: the ack is honoured and the start is ignored.
  - The earliest new accept is the cycle after the return to IDLE.
  - `rst`=0 in any state overrides everything on that edge.

## Timing
- Reset values, applied on the first edge with `rst`=0:
  - state = IDLE, `acc` = 0, `q` = 0
  - `busy` = 0, `rst_step` = 0, `enable` = 0, `data_out` = 0
  - `X_out` = 0, `Y_out` = 0, `phi_veer_out` = 0, `quarter_out` = 0
- Outputs are fully registered; there is no combinational path from any input to any output.
- Let E0 be the edge that accepts `start_in`.
  - `busy`=1 and `rst_step`=1 after E0. `rst_step` returns to 0 after E0+1.
  - WRAP executes at E0+1.
  - QUAD executes at E0+2 … E0+2+q.
  - `data_out` rises after edge E0+2+q, so latency is q+3 cycles (3 to 6).
- OUT → IDLE: `data_out` falls on the edge where `out_ack`=1 is sampled. `busy` falls on the same edge.
- Reset mid-operation: the block returns to IDLE with reset values on that edge. Any partial result is discarded, and no `rst_step` or `data_out` pulse is emitted.

## Test plan
- Reset, then `angle_in`=30.0 (0x1E000) with one-cycle `start_in`:
  - `rst_step` is high for exactly 1 cycle.
  - `data_out` rises 3 cycles after accept, with `quarter_out`=0, `phi_veer_out`=0x1E000, `X_out`=0x26DD4, `Y_out`=0.
- `angle_in`=200.0:
  - `quarter_out`=2, `phi_veer_out`=20.0 (0x14000), latency 5.
  - Outputs are held stable for 10 cycles with `out_ack`=0, then `out_ack`=1 drops `data_out` and `busy` on that edge.
- Exact boundaries:
  - 90.0 → q=1, phi=0.
  - 360.0 → q=0, phi=0.
  - 450.0 → q=1, phi=0, latency 4.
  - 359.999756 (0x167FFF) → q=3, phi=0x59FFF, latency 6.
- `start_in` pulsed during QUAD and again simultaneously with `out_ack` in OUT:
  - Both starts are ignored and the result matches the first angle.
  - A start one cycle later is accepted.
- `rst` driven low during the second QUAD cycle of 300.0:
  - All outputs show reset values on the next edge and `data_out` never rises.
  - A subsequent 45.0 request completes normally.
